// File: rtl/ctrl_pipe_reg.sv
// Parameterised control-bundle pipeline register with stall, flush, post-reset
// clear phase and a saturating count of bubbles delivered to the last stage.
module ctrl_pipe_reg #(
   parameter int             W       = 4,
   parameter int             DEPTH   = 1,
   parameter int             CLR_CYC = 1,
   parameter logic [W-1:0]   BUBBLE  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic [W-1:0]     d,
   input  logic             d_valid,
   output logic [W-1:0]     q,
   output logic             q_valid,
   output logic [DEPTH-1:0] stage_valid,
   output logic             busy,
   output logic [7:0]       bubble_cnt
);

   localparam logic [1:0] CLR_INIT = 2'(CLR_CYC);

   logic [DEPTH-1:0][W-1:0] data_q, data_d;
   logic [DEPTH-1:0]        valid_q, valid_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [1:0]              clr_q, clr_d;
   logic [7:0]              cnt_inc;

   assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      clr_d   = clr_q;
      if (clr_q != 2'd0) begin
         clr_d   = clr_q - 2'd1;
         data_d  = {DEPTH{BUBBLE}};
         valid_d = '0;
      end else if (flush) begin
         data_d  = {DEPTH{BUBBLE}};
         valid_d = '0;
         cnt_d   = cnt_inc;
      end else if (!stall) begin
         // Invalid entries are forced to BUBBLE so stale d never leaks downstream.
         data_d[0]  = d_valid ? d : BUBBLE;
         valid_d[0] = d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i]  = data_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
         if (!valid_d[DEPTH-1]) cnt_d = cnt_inc;
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         data_q  <= {DEPTH{BUBBLE}};
         valid_q <= '0;
         cnt_q   <= 8'd0;
         clr_q   <= CLR_INIT;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
      end
   end

   assign q           = data_q[DEPTH-1];
   assign q_valid     = valid_q[DEPTH-1];
   assign stage_valid = valid_q;
   assign busy        = (clr_q != 2'd0);
   assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Scoreboard bench: two pipeline configurations share stimulus, each with its
// own behavioural model; a monitor compares every edge's outputs.
module tb_ctrl_pipe_reg;

   localparam int         DEP [2] = '{2, 3};
   localparam int         CLR [2] = '{1, 0};
   localparam logic [3:0] BUB [2] = '{4'h0, 4'h9};

   typedef struct {
      logic [3:0] q;
      logic       qv;
      logic [3:0] sv;
      logic       busy;
      logic [7:0] cnt;
   } exp_t;

   logic       clk;
   logic       reset, stall, flush, d_valid;
   logic [3:0] d;
   logic [3:0] q0, q1;
   logic       qv0, qv1, busy0, busy1;
   logic [1:0] sv0;
   logic [2:0] sv1;
   logic [7:0] cnt0, cnt1;

   int checks   = 0;
   int failures = 0;

   exp_t sb0[$];
   exp_t sb1[$];

   logic [3:0] md [2][4];
   logic       mv [2][4];
   int         mcnt [2];
   int         mclr [2];

   ctrl_pipe_reg #(.W(4), .DEPTH(2), .CLR_CYC(1), .BUBBLE(4'h0)) dut0 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d), .d_valid(d_valid),
      .q(q0), .q_valid(qv0), .stage_valid(sv0), .busy(busy0), .bubble_cnt(cnt0));

   ctrl_pipe_reg #(.W(4), .DEPTH(3), .CLR_CYC(0), .BUBBLE(4'h9)) dut1 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .d(d), .d_valid(d_valid),
      .q(q1), .q_valid(qv1), .stage_valid(sv1), .busy(busy1), .bubble_cnt(cnt1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: apply the priority rules to one falling edge.
   task automatic step(int k, logic r, logic s, logic f, logic [3:0] dd, logic dv);
      if (r) begin
         for (int i = 0; i < 4; i++) begin md[k][i] = BUB[k]; mv[k][i] = 1'b0; end
         mcnt[k] = 0;
         mclr[k] = CLR[k];
      end else if (mclr[k] > 0) begin
         mclr[k]--;
         for (int i = 0; i < 4; i++) begin md[k][i] = BUB[k]; mv[k][i] = 1'b0; end
      end else if (f) begin
         for (int i = 0; i < 4; i++) begin md[k][i] = BUB[k]; mv[k][i] = 1'b0; end
         if (mcnt[k] < 255) mcnt[k]++;
      end else if (!s) begin
         for (int i = DEP[k] - 1; i > 0; i--) begin
            md[k][i] = md[k][i-1];
            mv[k][i] = mv[k][i-1];
         end
         md[k][0] = dv ? dd : BUB[k];
         mv[k][0] = dv;
         if (!mv[k][DEP[k]-1] && mcnt[k] < 255) mcnt[k]++;
      end
   endtask

   task automatic push_exp(int k);
      exp_t e;
      e.q    = md[k][DEP[k]-1];
      e.qv   = mv[k][DEP[k]-1];
      e.sv   = 4'd0;
      for (int i = 0; i < DEP[k]; i++) e.sv[i] = mv[k][i];
      e.busy = (mclr[k] != 0);
      e.cnt  = 8'(mcnt[k]);
      if (k == 0) sb0.push_back(e); else sb1.push_back(e);
   endtask

   // Called at a rising edge; the DUT consumes these inputs on the next falling edge.
   task automatic drive(logic r, logic s, logic f, logic [3:0] dd, logic dv);
      reset = r; stall = s; flush = f; d = dd; d_valid = dv;
      for (int k = 0; k < 2; k++) begin
         step(k, r, s, f, dd, dv);
         push_exp(k);
      end
      @(posedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("d0_q",     32'(q0),    32'(e.q));
            chk("d0_qv",    32'(qv0),   32'(e.qv));
            chk("d0_sv",    32'(sv0),   32'(e.sv));
            chk("d0_busy",  32'(busy0), 32'(e.busy));
            chk("d0_bcnt",  32'(cnt0),  32'(e.cnt));
         end
         if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("d1_q",     32'(q1),    32'(e.q));
            chk("d1_qv",    32'(qv1),   32'(e.qv));
            chk("d1_sv",    32'(sv1),   32'(e.sv));
            chk("d1_busy",  32'(busy1), 32'(e.busy));
            chk("d1_bcnt",  32'(cnt1),  32'(e.cnt));
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin : stimulus
      reset = 1'b1; stall = 1'b0; flush = 1'b0; d = 4'h0; d_valid = 1'b0;
      @(posedge clk);

      // Clear phase: first edge after reset ignores 4'hA, 4'h5 arrives at q.
      drive(1, 0, 0, 4'h0, 0);
      drive(1, 0, 0, 4'h0, 0);
      chk("rst_busy0", 32'(busy0), 32'd1);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_q1",    32'(q1),    32'h9);
      drive(0, 0, 0, 4'hA, 1);
      chk("clr_busy_done", 32'(busy0), 32'd0);
      chk("clr_ignored",   32'(sv0),   32'd0);
      drive(0, 0, 0, 4'h5, 1);
      drive(0, 0, 0, 4'h0, 0);
      chk("clr_q5",  32'(q0),  32'h5);
      chk("clr_qv5", 32'(qv0), 32'd1);

      // Latency on the DEPTH=3, CLR_CYC=0 instance.
      drive(1, 0, 0, 4'h0, 0);
      drive(0, 0, 0, 4'h1, 1);
      drive(0, 0, 0, 4'h2, 1);
      drive(0, 0, 0, 4'h3, 1);
      chk("lat_q1", 32'(q1), 32'h1);
      drive(0, 0, 0, 4'h0, 0);
      chk("lat_q2", 32'(q1), 32'h2);
      drive(0, 0, 0, 4'h0, 0);
      chk("lat_q3", 32'(q1), 32'h3);

      // Stall and flush together on a full pipeline.
      repeat (4) drive(0, 0, 0, 4'h7, 1);
      drive(0, 1, 1, 4'h7, 1);
      chk("flush_sv1", 32'(sv1), 32'd0);
      chk("flush_q1",  32'(q1),  32'h9);

      // Stall hold while d changes, then resume.
      repeat (4) drive(0, 0, 0, 4'(3 + $urandom_range(0, 12)), 1);
      repeat (3) drive(0, 1, 0, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      repeat (3) drive(0, 0, 0, 4'hE, 1);

      // Saturation of the bubble counter.
      drive(1, 0, 0, 4'h0, 0);
      repeat (300) drive(0, 0, 0, 4'($urandom_range(0, 15)), 0);
      chk("sat_cnt0", 32'(cnt0), 32'd255);
      chk("sat_cnt1", 32'(cnt1), 32'd255);

      // Mid-operation reset on a full pipeline.
      repeat (4) drive(0, 0, 0, 4'hB, 1);
      drive(1, 0, 0, 4'hB, 1);
      chk("mrst_busy0", 32'(busy0), 32'd1);
      chk("mrst_cnt0",  32'(cnt0),  32'd0);
      chk("mrst_qv1",   32'(qv1),   32'd0);

      // Randomised traffic.
      for (int n = 0; n < 500; n++) begin
         drive($urandom_range(0, 49) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) == 0,
               4'($urandom_range(0, 15)),
               $urandom_range(0, 9) < 6);
      end

      @(negedge clk);
      #3;
      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_reg.md
CTRL_PIPE_REG -- requirements
Module: ctrl_pipe_reg

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the control bundle width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 1, giving the number of register stages (1..4).
REQ-003 The block SHALL have parameter CLR_CYC, default 1, giving the number of post-reset clear cycles (0..3).
REQ-004 The block SHALL have parameter BUBBLE, default all-zero W bits, giving the value loaded into a stage holding no instruction.
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its falling edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port stall, input, 1 bit: hold all stages.
REQ-009 The block SHALL have port flush, input, 1 bit: replace all stages with bubbles.
REQ-010 The block SHALL have port d, input, W bits: upstream control bundle.
REQ-011 The block SHALL have port d_valid, input, 1 bit: d carries a real instruction.
REQ-012 The block SHALL have port q, output, W bits: last-stage control bundle.
REQ-013 The block SHALL have port q_valid, output, 1 bit: last stage holds a real instruction.
REQ-014 The block SHALL have port stage_valid, output, DEPTH bits: valid bit of each stage; bit 0 is the input-side stage.
REQ-015 The block SHALL have port busy, output, 1 bit: clear phase active.
REQ-016 The block SHALL have port bubble_cnt, output, 8 bits: saturating count of bubbles loaded into the last stage.

Function
REQ-017 Per falling edge, priority SHALL be: reset > clear phase > flush > stall > advance.
REQ-018 Clear phase: an internal counter clr_cnt SHALL load CLR_CYC on reset and decrement by 1 on each non-reset edge while nonzero; busy SHALL equal (clr_cnt != 0).
REQ-019 While busy=1, all stages SHALL hold BUBBLE with valid 0; d, d_valid, stall and flush are ignored; bubble_cnt holds.
REQ-020 With CLR_CYC=0, busy SHALL never assert and normal operation SHALL begin on the first edge after reset deasserts.
REQ-021 Flush: every stage SHALL load BUBBLE with valid 0; bubble_cnt SHALL increment by 1 (saturating); flush overrides a simultaneous stall.
REQ-022 Stall without flush: every stage and bubble_cnt SHALL hold.
REQ-023 Advance: stage 0 SHALL load d with valid d_valid; stage i SHALL load stage i-1 for i>=1.
REQ-024 On advance, bubble_cnt SHALL increment by 1 when the value entering the last stage has valid 0.
REQ-025 Input-to-q latency SHALL be exactly DEPTH advancing edges; stalled edges add one cycle each.
REQ-026 A stage with valid 0 SHALL hold exactly BUBBLE regardless of d (on advance with d_valid=0, stage 0 loads BUBBLE, not d).
REQ-027 bubble_cnt SHALL saturate at 255 and never wrap.
REQ-028 q, q_valid and stage_valid SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-029 On an edge with reset=1, every stage SHALL load BUBBLE with valid 0, bubble_cnt SHALL load 0, and clr_cnt SHALL load CLR_CYC.
REQ-030 Reset asserted mid-operation, including during stall, flush or clear phase, SHALL discard all contents and restart the clear phase.
REQ-031 After reset, outputs SHALL be q=BUBBLE, q_valid=0, stage_valid=0, busy=(CLR_CYC!=0), bubble_cnt=0.

Verification
REQ-032 Bench SHALL cover clear phase with W=4, DEPTH=2, CLR_CYC=1: reset then d=4'hA, d_valid=1 on the first edge -> busy=1 for one edge, 4'hA ignored; d=4'h5 on the next edge -> q=4'h5, q_valid=1 two edges later.
REQ-033 Bench SHALL cover latency with DEPTH=3, CLR_CYC=0: stream 4'h1, 4'h2, 4'h3 valid -> q shows 4'h1 on the third edge, then 4'h2 and 4'h3 on consecutive edges.
REQ-034 Bench SHALL cover stall and flush together: pipeline full of valid 4'h7, stall=1 and flush=1 on the same edge -> all stage_valid=0, q=BUBBLE, bubble_cnt +1.
REQ-035 Bench SHALL cover stall hold: stall=1 for 3 edges while d changes -> q, stage_valid and bubble_cnt unchanged; advance resumes on the edge after stall=0.
REQ-036 Bench SHALL cover saturation: 300 consecutive advances with d_valid=0 -> bubble_cnt reaches 255 and holds at 255.
REQ-037 Bench SHALL cover mid-operation reset: reset=1 for one edge while busy=0 and the pipeline is full -> all outputs at their reset values and busy=1 on the next edge.
